// File: rtl/pat_seq_ctrl.sv
// rtl/pat_seq_ctrl.sv - programmable beat pattern sequencer with ready/valid output
module pat_seq_ctrl #(
    parameter int DW = 8
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic          cfg_dv,
    input  logic [DW-1:0] cfg_data,
    input  logic [2:0]    cfg_len,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          stop,
    input  logic          o_ready,
    output logic          o_dv,
    output logic [DW-1:0] o_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   beat_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    len_q, len_d;
    logic          loop_q, loop_d;
    logic          o_dv_q, o_dv_d;
    logic [DW-1:0] o_data_q, o_data_d;
    logic          done_q, done_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          tbl_dv_q   [8];
    logic [DW-1:0] tbl_data_q [8];

    logic          ld;
    logic [2:0]    ld_idx;
    logic [2:0]    nxt_idx;
    logic          beat_xfer;

    // Pattern table: reloads its default pattern on reset, writable only while idle
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                tbl_dv_q[i]   <= 1'b0;
                tbl_data_q[i] <= '0;
            end
            tbl_dv_q[0]   <= 1'b1;
            tbl_data_q[0] <= DW'(7);
            tbl_dv_q[2]   <= 1'b1;
            tbl_data_q[2] <= DW'(5);
        end else if (cfg_we && state_q == IDLE) begin
            tbl_dv_q[cfg_addr]   <= cfg_dv;
            tbl_data_q[cfg_addr] <= cfg_data;
        end
    end

    // Next-state logic: sequencing, beat hand-off and beat counting
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        loop_d   = loop_q;
        o_dv_d   = o_dv_q;
        o_data_d = o_data_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        ld       = 1'b0;
        ld_idx   = 3'd0;
        nxt_idx  = (idx_q == len_q) ? 3'd0 : idx_q + 3'd1;
        // A gap beat never waits for the consumer; a valid beat waits for o_ready
        beat_xfer = (state_q == RUN) && o_dv_q && o_ready;

        if (beat_xfer && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    idx_d   = 3'd0;
                    len_d   = cfg_len;
                    loop_d  = cfg_loop;
                    cnt_d   = 16'd0;
                    ld      = 1'b1;
                    ld_idx  = 3'd0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    o_dv_d   = 1'b0;
                    o_data_d = '0;
                end else if (!o_dv_q || o_ready) begin
                    if (idx_q == len_q && !loop_q) begin
                        state_d  = DONE;
                        o_dv_d   = 1'b0;
                        o_data_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d  = nxt_idx;
                        ld     = 1'b1;
                        ld_idx = nxt_idx;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                o_dv_d   = 1'b0;
                o_data_d = '0;
            end
        endcase

        if (ld) begin
            o_dv_d   = tbl_dv_q[ld_idx];
            o_data_d = tbl_dv_q[ld_idx] ? tbl_data_q[ld_idx] : '0;
        end
    end

    // Control and output registers
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            len_q    <= 3'd0;
            loop_q   <= 1'b0;
            o_dv_q   <= 1'b0;
            o_data_q <= '0;
            done_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            o_dv_q   <= o_dv_d;
            o_data_q <= o_data_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_dv     = o_dv_q;
    assign o_data   = o_data_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_pat_seq_ctrl.sv
// tb/tb_pat_seq_ctrl.sv - directed vector bench for pat_seq_ctrl
module tb_pat_seq_ctrl;

    logic        sclk = 1'b0;
    logic        rst_n, cfg_we, cfg_dv, cfg_loop, start, stop, o_ready;
    logic [2:0]  cfg_addr, cfg_len;
    logic [7:0]  cfg_data;
    logic        o_dv, busy, done;
    logic [7:0]  o_data;
    logic [15:0] beat_cnt;

    int n_vec = 0;
    int n_bad = 0;

    pat_seq_ctrl #(.DW(8)) dut (
        .sclk(sclk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_dv(cfg_dv), .cfg_data(cfg_data), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
        .start(start), .stop(stop), .o_ready(o_ready), .o_dv(o_dv), .o_data(o_data),
        .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic        rst_n, start, stop, rdy, we;
        logic [2:0]  addr;
        logic        wdv;
        logic [7:0]  wdata;
        logic [2:0]  len;
        logic        loop;
        logic        e_dv;
        logic [7:0]  e_data;
        logic        e_busy, e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, st, sp, rdy, we, input logic [2:0] addr,
                       input logic wdv, input logic [7:0] wdata, input logic [2:0] len,
                       input logic loop, input logic edv, input logic [7:0] edata,
                       input logic ebusy, edone, input logic [15:0] ecnt);
        vec_t v;
        v.rst_n = r; v.start = st; v.stop = sp; v.rdy = rdy; v.we = we;
        v.addr = addr; v.wdv = wdv; v.wdata = wdata; v.len = len; v.loop = loop;
        v.e_dv = edv; v.e_data = edata; v.e_busy = ebusy; v.e_done = edone; v.e_cnt = ecnt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic edv, input logic [7:0] edata,
                         input logic ebusy, edone, input logic [15:0] ecnt);
        n_vec++;
        if (o_dv !== edv || o_data !== edata || busy !== ebusy || done !== edone || beat_cnt !== ecnt) begin
            n_bad++;
            $display("FAIL %s: got dv=%b data=%h busy=%b done=%b cnt=%h, want dv=%b data=%h busy=%b done=%b cnt=%h",
                     name, o_dv, o_data, busy, done, beat_cnt, edv, edata, ebusy, edone, ecnt);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge sclk);
        rst_n = v.rst_n; start = v.start; stop = v.stop; o_ready = v.rdy;
        cfg_we = v.we; cfg_addr = v.addr; cfg_dv = v.wdv; cfg_data = v.wdata;
        cfg_len = v.len; cfg_loop = v.loop;
        @(posedge sclk);
        #1;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; o_ready = 1'b0; cfg_we = 1'b0;
        cfg_addr = 3'd0; cfg_dv = 1'b0; cfg_data = 8'd0; cfg_len = 3'd0; cfg_loop = 1'b0;

        //   rst st sp rdy we addr dv data   len loop | dv data  busy done cnt
        add(0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 3'd0, 0,   0, 8'h00, 0, 0, 16'd0); // reset
        // default pass, len=2 no loop; gap beat advances with o_ready=0
        add(1, 1, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 1, 0, 16'd1);
        add(1, 0, 0, 0, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h05, 1, 0, 16'd1);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 0, 1, 16'd2);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 0, 0, 16'd2);
        // backpressure at entry0 for 3 cycles
        add(1, 1, 0, 0, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 0, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 0, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 0, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 1, 0, 16'd1);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h05, 1, 0, 16'd1);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 0, 1, 16'd2);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 0, 0, 16'd2);
        // write entry1, looping len=1, then stop with a beat in flight
        add(1, 0, 0, 1, 1, 3'd1, 1, 8'hA5, 3'd1, 1,   0, 8'h00, 0, 0, 16'd2);
        add(1, 1, 0, 1, 0, 3'd0, 0, 8'h00, 3'd1, 1,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd1, 1,   1, 8'hA5, 1, 0, 16'd1);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd1, 1,   1, 8'h07, 1, 0, 16'd2);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd1, 1,   1, 8'hA5, 1, 0, 16'd3);
        add(1, 0, 1, 1, 0, 3'd0, 0, 8'h00, 3'd1, 1,   0, 8'h00, 0, 0, 16'd4);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd1, 1,   0, 8'h00, 0, 0, 16'd4);
        // write during RUN ignored; start during RUN ignored
        add(1, 1, 0, 0, 0, 3'd0, 0, 8'h00, 3'd1, 1,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 1, 1, 3'd0, 1, 8'h33, 3'd1, 1,   1, 8'hA5, 1, 0, 16'd1);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd1, 1,   1, 8'h07, 1, 0, 16'd2);
        add(1, 1, 0, 0, 0, 3'd0, 0, 8'h00, 3'd1, 1,   1, 8'h07, 1, 0, 16'd2);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd1, 1,   1, 8'hA5, 1, 0, 16'd3);
        add(1, 0, 1, 0, 0, 3'd0, 0, 8'h00, 3'd1, 1,   0, 8'h00, 0, 0, 16'd3);
        // start+stop together in IDLE
        add(1, 1, 1, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 0, 0, 16'd3);
        // reset mid-run at idx=1, then default pattern replays
        add(1, 1, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'hA5, 1, 0, 16'd1);
        add(0, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 0, 0, 16'd0);
        add(1, 1, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h07, 1, 0, 16'd0);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 1, 0, 16'd1);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   1, 8'h05, 1, 0, 16'd1);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 0, 1, 16'd2);
        add(1, 0, 0, 1, 0, 3'd0, 0, 8'h00, 3'd2, 0,   0, 8'h00, 0, 0, 16'd2);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            check($sformatf("vec%0d", i), vq[i].e_dv, vq[i].e_data, vq[i].e_busy, vq[i].e_done, vq[i].e_cnt);
        end

        // beat counter saturation: loop on entry0 with o_ready held high
        v = vq[0];
        drive(v);
        v.rst_n = 1'b1; v.start = 1'b1; v.rdy = 1'b1; v.len = 3'd0; v.loop = 1'b1;
        drive(v);
        check("sat_start", 1'b1, 8'h07, 1'b1, 1'b0, 16'd0);
        v.start = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            drive(v);
            if (i == 9) check("sat_early", 1'b1, 8'h07, 1'b1, 1'b0, 16'd10);
        end
        check("sat_full", 1'b1, 8'h07, 1'b1, 1'b0, 16'hFFFF);
        v.stop = 1'b1;
        drive(v);
        check("sat_stop", 1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF);
        v.stop = 1'b0;
        drive(v);
        check("sat_hold", 1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pat_seq_ctrl.md
PAT_SEQ_CTRL -- requirements
Module: pat_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: DW, default 8, pattern data width.
REQ-002 Port sclk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 Port cfg_we, input, 1, pattern-table write strobe.
REQ-005 Port cfg_addr, input, 3, table entry index 0..7.
REQ-006 Port cfg_dv, input, 1, valid flag for the written entry (0 = gap beat).
REQ-007 Port cfg_data, input, DW, data for the written entry.
REQ-008 Port cfg_len, input, 3, index of the last entry in a pass, sampled at start.
REQ-009 Port cfg_loop, input, 1, 1 = wrap to entry 0 after the last entry, sampled at start.
REQ-010 Port start, input, 1, single-cycle run request.
REQ-011 Port stop, input, 1, single-cycle abort request.
REQ-012 Port o_ready, input, 1, downstream accepts the current beat.
REQ-013 Port o_dv, output, 1, registered beat valid.
REQ-014 Port o_data, output, DW, registered beat data; 0 whenever o_dv=0.
REQ-015 Port busy, output, 1, high in RUN.
REQ-016 Port done, output, 1, one-cycle pulse on normal completion of a non-looping pass.
REQ-017 Port beat_cnt, output, 16, count of beats transferred since the last start.

Function
REQ-018 The table SHALL hold 8 entries of {dv, data}; reset contents: entry0={1,7}, entry2={1,5}, all others={0,0}.
REQ-019 cfg_we SHALL write entry cfg_addr only when state is IDLE; writes in RUN or DONE are ignored.
REQ-020 FSM states SHALL be IDLE, RUN, DONE.
REQ-021 IDLE: start=1 and stop=0 -> RUN, idx=0, latch cfg_len/cfg_loop, beat_cnt=0; otherwise remain IDLE.
REQ-022 In the first RUN cycle (one cycle after start), o_dv/o_data SHALL present entry[0].
REQ-023 RUN: o_dv/o_data SHALL present entry[idx]; o_data forced to 0 when entry dv=0.
REQ-024 A valid beat (o_dv=1) SHALL be held unchanged until a rising edge with o_ready=1; then idx advances.
REQ-025 A gap beat (o_dv=0) SHALL last exactly one cycle regardless of o_ready, then idx advances.
REQ-026 Advance from idx=len: loop=1 -> idx=0, stay RUN; loop=0 -> DONE, o_dv=0, o_data=0.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 stop=1 in RUN SHALL force IDLE at the next edge, o_dv=0, o_data=0, no done pulse; a beat with o_ready=1 in that same cycle is counted.
REQ-029 start in RUN or DONE SHALL be ignored; start and stop together in IDLE SHALL leave the block in IDLE.
REQ-030 beat_cnt SHALL increment by 1 per transferred valid beat, saturating at 16'hFFFF, and hold its value after stop or DONE until the next start.
REQ-031 busy SHALL equal (state==RUN); done SHALL be registered.

Reset
REQ-032 rst_n=0 at an edge SHALL set state=IDLE, idx=0, o_dv=0, o_data=0, busy=0, done=0, beat_cnt=0, and the table to its REQ-018 contents, including mid-run.

Verification
REQ-033 Reset, cfg_len=2, loop=0, o_ready=1, start -> o_dv/o_data = 1/7, 0/0, 1/5 on three consecutive cycles, then done=1 for one cycle, beat_cnt=2.
REQ-034 Same run with o_ready=0 for 3 cycles at entry0 -> o_dv=1, o_data=7 held 4 cycles; the sequence then completes unchanged.
REQ-035 Write entry1={1,8'hA5}, len=1, loop=1, o_ready=1 -> 7, A5, 7, A5 repeating; stop -> o_dv=0 next cycle, no done, busy=0.
REQ-036 cfg_we during RUN to entry0 -> ignored; next pass still outputs 7 at entry0.
REQ-037 rst_n=0 mid-run at idx=1 -> next cycle all outputs 0, IDLE; a later start replays the default pattern.
REQ-038 start and stop together in IDLE -> busy stays 0; start during RUN -> no restart, idx unaffected.
